// File: rtl/riscvi2oi_muldiv_arb_pkg.sv
// Shared constants for the two-requester mul/div arbiter: message widths,
// field positions and function codes.
package riscvi2oi_muldiv_arb_pkg;

  localparam int REQ_W  = 67;
  localparam int RESP_W = 64;
  localparam int FN_W   = 3;
  localparam int OP_W   = 32;

  localparam int FN_LSB  = 64;
  localparam int OPA_LSB = 32;
  localparam int OPB_LSB = 0;

  typedef enum logic [FN_W-1:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } muldiv_fn_e;

  function automatic logic [FN_W-1:0] msg_fn(input logic [REQ_W-1:0] msg);
    return msg[FN_LSB +: FN_W];
  endfunction

  function automatic logic [OP_W-1:0] msg_opa(input logic [REQ_W-1:0] msg);
    return msg[OPA_LSB +: OP_W];
  endfunction

  function automatic logic [OP_W-1:0] msg_opb(input logic [REQ_W-1:0] msg);
    return msg[OPB_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/riscvi2oi_muldiv_arb_tagq.sv
// In-order tag queue: DEPTH x 1-bit circular FIFO recording which requester
// owns each request outstanding in the shared unit.
module riscvi2oi_muldiv_tagq #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_id;
  end

  assign head  = mem[head_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/riscvi2oi_muldiv_arb.sv
// Round-robin sharing of one pipelined mul/div unit between two requesters;
// responses are steered back by an in-order tag queue with zero added latency.
module riscvi2oi_muldiv_arb
  import riscvi2oi_muldiv_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [REQ_W-1:0]  req0_msg,
  input  logic              req0_val,
  output logic              req0_rdy,
  input  logic [REQ_W-1:0]  req1_msg,
  input  logic              req1_val,
  output logic              req1_rdy,

  output logic [RESP_W-1:0] resp0_msg,
  output logic              resp0_val,
  input  logic              resp0_rdy,
  output logic [RESP_W-1:0] resp1_msg,
  output logic              resp1_val,
  input  logic              resp1_rdy,

  output logic [REQ_W-1:0]  md_req_msg,
  output logic              md_req_val,
  input  logic              md_req_rdy,
  input  logic [RESP_W-1:0] md_resp_msg,
  input  logic              md_resp_val,
  output logic              md_resp_rdy,

  output logic              err_orphan
);

  logic prio;
  logic err_flag;
  logic winner;
  logic can_issue;
  logic any_val;
  logic push;
  logic pop;
  logic head;
  logic full;
  logic empty;
  logic head_rdy;
  logic orphan;

  riscvi2oi_muldiv_tagq #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_tagq (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (winner),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Request side: the favoured requester only matters when both are valid.
  always_comb begin
    any_val   = req0_val || req1_val;
    winner    = (req0_val && req1_val) ? prio : req1_val;
    can_issue = !reset && !full && md_req_rdy;
  end

  assign md_req_val = can_issue && any_val;
  assign md_req_msg = winner ? req1_msg : req0_msg;
  assign req0_rdy   = can_issue && !winner;
  assign req1_rdy   = can_issue && winner;
  assign push       = md_req_val && md_req_rdy;

  // Response side: the head tag selects which requester sees the result.
  always_comb begin
    head_rdy = head ? resp1_rdy : resp0_rdy;
    orphan   = md_resp_val && empty;
  end

  assign resp0_val   = !reset && md_resp_val && !empty && !head;
  assign resp1_val   = !reset && md_resp_val && !empty && head;
  assign resp0_msg   = md_resp_msg;
  assign resp1_msg   = md_resp_msg;
  assign md_resp_rdy = !reset && !empty && head_rdy;
  assign pop         = md_resp_val && md_resp_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (push) begin
      prio <= !winner;
    end
  end

  // Sticky until reset: a result arrived that nobody is waiting for.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag <= 1'b0;
    end else if (orphan) begin
      err_flag <= 1'b1;
    end
  end

  assign err_orphan = err_flag;

endmodule

// File: doc/riscvi2oi_muldiv_arb.md
Name: riscvi2oi_muldiv_arb

Overview:
- Shares one pipelined mul/div unit between two requesters (e.g. core X-stage and a coprocessor/second hart).
- Round-robin arbitration on the request side; an in-order tag queue routes each unit response back to the requester that issued it.
- Sits between the requesters' val/rdy muldiv ports and the unit's muldivreq/muldivresp ports; it does not modify payloads.

Parameters:
- DEPTH, 4, max outstanding requests tracked (tag-queue entries); power of two, ≥2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req0_msg  in  67  {fn[66:64], a[63:32], b[31:0]}; fn 0=mul, 1=div, 2=divu, 3=rem, 4=remu.
- req0_val  in  1  requester 0 request valid.
- req0_rdy  out  1  requester 0 request accepted.
- req1_msg, req1_val, req1_rdy: as req0, for requester 1.
- resp0_msg  out  64  result routed to requester 0.
- resp0_val  out  1  response valid to requester 0.
- resp0_rdy  in  1  requester 0 response ready.
- resp1_msg, resp1_val, resp1_rdy: as resp0, for requester 1.
- md_req_msg  out  67  request to the unit.
- md_req_val  out  1  request valid to the unit.
- md_req_rdy  in  1  unit ready for a request.
- md_resp_msg  in  64  unit result.
- md_resp_val  in  1  unit result valid.
- md_resp_rdy  out  1  ready for the unit result.
- err_orphan  out  1  sticky flag: the unit produced a response with no outstanding tag.

Behaviour:
- Reset (async, takes effect immediately): prio=0 (requester 0 favoured), queue empty, count=0, err_orphan=0. Outputs while reset is high: all *_val=0, all *_rdy=0.
- Issue enable: can_issue = !full && md_req_rdy. No push while full, even if a pop happens in the same cycle.
- Grant is combinational:
  - If only one requester is valid, it wins.
  - If both are valid, requester[prio] wins.
- md_req_val = can_issue && (req0_val || req1_val). md_req_msg = the winner's msg; it is req0_msg when neither requester is valid.
- reqN_rdy = can_issue && (winner == N). reqN_rdy never depends on reqN_val of the other requester beyond the grant decision. Loser rdy=0.
- Request fire (md_req_val && md_req_rdy):
  - Push the winner id into the tail of the queue.
  - Next cycle prio = !winner.
  - prio is unchanged on cycles with no fire.
- Tag queue:
  - DEPTH-entry circular FIFO of 1-bit ids, with head/tail pointers that wrap modulo DEPTH.
  - count in 0..DEPTH; full when count==DEPTH, empty when count==0.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Response routing (head id h, combinational, zero added latency):
  - resp{h}_val = md_resp_val && !empty. resp{!h}_val = 0.
  - resp0_msg = resp1_msg = md_resp_msg.
  - md_resp_rdy = !empty && resp{h}_rdy.
- Response fire (md_resp_val && md_resp_rdy): pop the head.
- Empty queue with md_resp_val=1:
  - md_resp_rdy=0 and no resp*_val asserted.
  - err_orphan is set on the next edge and holds until reset.
- Ordering: the unit is in-order, so responses map FIFO to requests. The arbiter adds 0 cycles on both the request and response paths.
- Back-pressure: while resp{h}_rdy=0, further responses stall in the unit. The requester must hold stall_* high on the unit accordingly; this is outside this block.
- Starvation bound: a continuously valid requester is granted within 2 issue opportunities.
- Reset mid-operation: queued tags are discarded. The unit must be reset in the same cycle. Any late unit response after reset release sets err_orphan.

Decomposition:
- Shared package/include (riscvi2oi-MulDivArbConsts): msg widths (REQ_W=67, RESP_W=64, FN_W=3), fn codes, field bit positions.
- Sub-module riscvi2oi_muldiv_tagq: parameterised DEPTH x 1-bit FIFO exposing push, pop, head, full, empty. The arbiter top holds the prio flop, grant muxing and err_orphan.

Test Plan:
- Single requester, unit ready:
  - req0 mul 0x00000008*0x00000003 -> resp0 returns 0x00000000_00000018.
  - resp1_val stays 0; queue returns to empty.
- Both requesters valid every cycle, req0 mul 0xfffffff8*0x8, req1 div 0x00000222/0x2a:
  - Grants alternate 0,1,0,1.
  - resp0 returns 0xffffffff_ffffffc0 and resp1 returns 0x00000000_0000000d, in issue order.
- Fill: hold resp0_rdy=0 and issue DEPTH requests:
  - The 5th request sees req*_rdy=0 until the first response pops.
  - No entries are lost; the wrap-around is exercised by 3 full fill/drain passes.
- Simultaneous push and pop at count==DEPTH-1: count stays constant and ids route correctly (mixed remu 0xf5fe4fbc,0x4eb6 -> 0x000006f0_00032012).
- Orphan: inject md_resp_val with an empty queue -> md_resp_rdy=0, no resp val, err_orphan=1 next cycle, cleared only by reset.
- Async reset asserted mid-burst (between clock edges): outputs go to reset values immediately; after release, prio=0 and the first grant goes to req0 when both are valid.
